dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder for the processor's data-memory port. It serves `address_dmem`/`d_dmem`/`wren_dmem` with a registered `q_dmem` and backs the low address space with a synchronous RAM. The top 16 words form a memory-mapped I/O window: a cycle counter, a store counter and an output FIFO that an external consumer drains over a valid/ready port. It sits beside the processor in the skeleton, in place of the plain dmem macro, so test programs can stream results out instead of relying on hierarchical register probes.

## Interface
- `ADDR_WIDTH`, 12: word-address width; RAM depth is 2^ADDR_WIDTH words.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, at least 2.
- `clock`, input, 1: single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low.
- `address_dmem`, input, ADDR_WIDTH: word address from the processor memory stage.
- `d_dmem`, input, 32: store data.
- `wren_dmem`, input, 1: write enable.
- `q_dmem`, output, 32: registered read data.
- `out_data`, output, 32: FIFO head word.
- `out_valid`, output, 1: FIFO non-empty.
- `out_ready`, input, 1: consumer accepts the head word this cycle.
- `overflow`, output, 1: sticky flag set when a push is dropped.

## Operation
- The MMIO window is every address with `address_dmem[ADDR_WIDTH-1:4]` all ones. All other addresses are the RAM region.
- RAM region:
  - Write when `wren_dmem` is high.
  - Read is every cycle.
  - Read-during-write to the same address returns the old data.
  - RAM contents are not cleared by reset.
- MMIO registers (word offset in the window):
  - 0x0, CYCLES, read-only: 32-bit free-running count of cycles since reset deassertion; wraps at 2^32.
  - 0x1, STORES, read-only: number of RAM-region writes; wraps at 2^32.
  - 0x2, LAST_ST, read-only: address of the most recent RAM-region write, zero-extended.
  - 0x4, TX_PUSH, write-only: a write pushes `d_dmem` into the FIFO; reads return 0.
  - 0x5, TX_STAT, read-only: bit 31 is `overflow`, low bits are the FIFO occupancy count (0..FIFO_DEPTH), other bits are 0.
  - 0x6, TX_CLR: any write clears `overflow`; reads return 0.
  - Writes to read-only or unmapped offsets are ignored.
  - Reads of unmapped offsets return 0.
  - MMIO writes never modify RAM.
- FIFO push/pop rules:
  - Pop occurs when `out_valid && out_ready`.
  - Push occurs when not full, or when full with a pop in the same cycle.
  - A push to a full FIFO with no simultaneous pop is dropped and sets `overflow`.
  - If a TX_CLR write and a dropped push land in the same cycle, the set wins.
- `out_data` is undefined when `out_valid` is low. It must be stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `q_dmem` = 0, `out_valid` = 0, `out_data` = 0, `overflow` = 0.
  - CYCLES, STORES and LAST_ST = 0.
  - FIFO empty.
- Read latency is 1. The address presented before edge N gives `q_dmem` valid after edge N, for both RAM and MMIO.
- Timing of MMIO reads:
  - A CYCLES read returns the counter value from before edge N.
  - A TX_STAT read returns the occupancy from before that edge's push or pop.
- FIFO latency:
  - A push into an empty FIFO raises `out_valid` after the same edge; there is no combinational fall-through.
  - A pop and push together on a non-empty FIFO leave the count unchanged.
- STORES and LAST_ST update on the edge of the write. A read of them in the following cycle sees the new value.
- Asserting `reset` mid-operation:
  - Immediately empties the FIFO and zeroes all counters and outputs.
  - A write in progress that cycle is lost.

## Structure
- A shared package `dmem_pkg` holds:
  - MMIO offset constants: `MMIO_CYCLES`, `MMIO_STORES`, `MMIO_LAST_ST`, `MMIO_TX_PUSH`, `MMIO_TX_STAT`, `MMIO_TX_CLR`.
  - A function for the window-decode predicate.
- One sub-module, `tx_fifo`:
  - Parameterised by `FIFO_DEPTH`.
  - Implemented as a circular buffer with read/write pointers plus a count.
  - Exposes push, pop, full, empty, count and head data.
- Decode, RAM, counters and overflow logic live in the top module.

## Test plan
- Reset, then store 0x0000_0007 to address 5 and read address 5 next cycle → `q_dmem` = 7. Then read STORES → 1 and LAST_ST → 5.
- Same-cycle write of 9 and read of address 5 (holding 7) → `q_dmem` = 7. A read in the next cycle → 9.
- Push 1..8 to TX_PUSH with `out_ready` = 0 → TX_STAT reads 8 and `overflow` = 0. Push 9 → dropped, `overflow` = 1, TX_STAT = 0x8000_0008.
- FIFO full, push 10 while `out_ready` = 1 → pops 1 and accepts 10, count stays 8. Draining yields 2..8, 10 in order, then `out_valid` = 0.
- Two CYCLES reads 3 cycles apart differ by 3.
- Store 0xDEAD to offset 0x4 of the window, then read RAM at that same address → unchanged.
- Write TX_CLR → `overflow` = 0.
- Assert `reset` with 5 entries queued → `out_valid` drops with no clock edge; after release TX_STAT = 0 and CYCLES counts from 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets
// and the window-decode predicate.
package dmem_pkg;

  localparam logic [3:0] MMIO_CYCLES  = 4'h0;
  localparam logic [3:0] MMIO_STORES  = 4'h1;
  localparam logic [3:0] MMIO_LAST_ST = 4'h2;
  localparam logic [3:0] MMIO_TX_PUSH = 4'h4;
  localparam logic [3:0] MMIO_TX_STAT = 4'h5;
  localparam logic [3:0] MMIO_TX_CLR  = 4'h6;

  // The MMIO window is the top 16 words: all address bits above bit 3 set.
  function automatic logic in_mmio_window(input logic [31:0] addr,
                                          input int unsigned addr_width);
    logic hit;
    hit = 1'b1;
    for (int unsigned i = 4; i < addr_width; i++) begin
      if (!addr[i]) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Output FIFO for the MMIO transmit port: circular buffer with read/write
// pointers and an occupancy count; head word is registered storage.
module tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [31:0]                   push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [31:0]                   head
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous RAM for the low address space plus an
// MMIO window with cycle/store counters and a drained output FIFO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_dmem,
  input  logic [31:0]           d_dmem,
  input  logic                  wren_dmem,
  output logic [31:0]           q_dmem,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [2**ADDR_WIDTH];
  logic [31:0]   ram_q;
  logic [31:0]   mmio_q;
  logic          rd_is_mmio;
  logic [31:0]   cycles;
  logic [31:0]   stores;
  logic [31:0]   last_st;
  logic [31:0]   mmio_rd;

  logic          is_mmio;
  logic [3:0]    offset;
  logic          ram_we;
  logic          push_req;
  logic          clr_req;
  logic          pop;
  logic          dropped;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign is_mmio  = in_mmio_window(32'(address_dmem), ADDR_WIDTH);
  assign offset   = address_dmem[3:0];
  // Gating with reset drops a store that coincides with an active reset.
  assign ram_we   = wren_dmem && !is_mmio && reset;
  assign push_req = wren_dmem && is_mmio && (offset == MMIO_TX_PUSH);
  assign clr_req  = wren_dmem && is_mmio && (offset == MMIO_TX_CLR);
  assign out_valid = !fifo_empty;
  assign pop      = out_valid && out_ready;
  assign dropped  = push_req && fifo_full && !pop;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (d_dmem),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

  always_comb begin
    mmio_rd = '0;
    case (offset)
      MMIO_CYCLES:  mmio_rd = cycles;
      MMIO_STORES:  mmio_rd = stores;
      MMIO_LAST_ST: mmio_rd = last_st;
      MMIO_TX_STAT: begin
        mmio_rd[31]     = overflow;
        mmio_rd[CW-1:0] = fifo_count;
      end
      default:      mmio_rd = '0;
    endcase
  end

  // RAM has no reset so it maps onto block memory; read returns old data.
  always_ff @(posedge clock) begin
    if (ram_we) ram[address_dmem] <= d_dmem;
    ram_q <= ram[address_dmem];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles     <= '0;
      stores     <= '0;
      last_st    <= '0;
      rd_is_mmio <= 1'b1;
      mmio_q     <= '0;
      overflow   <= 1'b0;
    end else begin
      cycles     <= cycles + 32'd1;
      rd_is_mmio <= is_mmio;
      mmio_q     <= mmio_rd;
      if (ram_we) begin
        stores  <= stores + 32'd1;
        last_st <= 32'(address_dmem);
      end
      if (dropped)      overflow <= 1'b1;
      else if (clr_req) overflow <= 1'b0;
    end
  end

  // Select register resets to the MMIO side so q_dmem reads 0 out of reset.
  assign q_dmem = rd_is_mmio ? mmio_q : ram_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a read scoreboard and a FIFO model.
module tb_dmem_responder;

  localparam int unsigned AW = 12;
  localparam int unsigned FD = 8;

  localparam logic [AW-1:0] A_CYC  = 12'hFF0;
  localparam logic [AW-1:0] A_STO  = 12'hFF1;
  localparam logic [AW-1:0] A_LAST = 12'hFF2;
  localparam logic [AW-1:0] A_PUSH = 12'hFF4;
  localparam logic [AW-1:0] A_STAT = 12'hFF5;
  localparam logic [AW-1:0] A_CLR  = 12'hFF6;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [31:0]   d_dmem;
  logic          wren;
  logic [31:0]   q_dmem;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] model_fifo[$];
  logic        model_ovf;
  logic [31:0] c1;

  always #5 clock = ~clock;

  dmem_responder #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address),
    .d_dmem       (d_dmem),
    .wren_dmem    (wren),
    .q_dmem       (q_dmem),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_q(input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_q();
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, q_dmem, e);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string tag);
    expect_q(e, tag);
    address = a;
    wren    = 1'b0;
    tick();
    compare_q();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    address = a;
    d_dmem  = d;
    wren    = 1'b1;
    tick();
    wren    = 1'b0;
  endtask

  task automatic push_tx(input logic [31:0] d);
    if (out_ready && model_fifo.size() != 0) void'(model_fifo.pop_front());
    if (model_fifo.size() < FD) model_fifo.push_back(d);
    else model_ovf = 1'b1;
    wr(A_PUSH, d);
  endtask

  function automatic logic [31:0] stat_exp();
    logic [31:0] s;
    s = 32'(model_fifo.size());
    s[31] = model_ovf;
    return s;
  endfunction

  initial begin
    reset = 1'b0; address = '0; d_dmem = '0; wren = 1'b0; out_ready = 1'b0;
    model_ovf = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_q", q_dmem, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    address = A_CYC;
    reset   = 1'b1;
    rd(A_CYC, 32'd0, "cycles_start");

    wr(12'd5, 32'h0000_0007);
    rd(12'd5, 32'd7, "ram_rd");
    rd(A_STO, 32'd1, "stores");
    rd(A_LAST, 32'd5, "last_st");

    expect_q(32'd7, "rdw_old");
    address = 12'd5; d_dmem = 32'd9; wren = 1'b1;
    tick();
    wren = 1'b0;
    compare_q();
    rd(12'd5, 32'd9, "rdw_new");

    for (int i = 1; i <= 8; i++) push_tx(32'(i));
    rd(A_STAT, stat_exp(), "stat_full");
    check("ovf_full", 32'(overflow), 32'(model_ovf));
    push_tx(32'd9);
    check("ovf_drop", 32'(overflow), 32'(model_ovf));
    rd(A_STAT, stat_exp(), "stat_drop");
    check("head_1", out_data, model_fifo[0]);

    out_ready = 1'b1;
    push_tx(32'd10);
    out_ready = 1'b0;
    check("head_2", out_data, model_fifo[0]);
    rd(A_STAT, stat_exp(), "stat_pushpop");

    while (model_fifo.size() != 0) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", out_data, model_fifo.pop_front());
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    rd(A_STAT, stat_exp(), "stat_empty");

    address = A_CYC;
    tick();
    c1 = q_dmem;
    tick();
    tick();
    rd(A_CYC, c1 + 32'd3, "cycles_delta");

    wr(12'h004, 32'h0000_1234);
    push_tx(32'h0000_DEAD);
    rd(12'h004, 32'h0000_1234, "ram_untouched");
    rd(A_PUSH, 32'd0, "push_reads0");
    check("head_dead", out_data, model_fifo[0]);
    check("ovf_sticky", 32'(overflow), 32'(model_ovf));

    wr(A_CLR, 32'd0);
    model_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    rd(A_STAT, stat_exp(), "stat_after_clr");
    rd(A_LAST, 32'h0000_0004, "last_st_2");

    for (int i = 1; i <= 4; i++) push_tx(32'(100 + i));
    rd(A_STAT, stat_exp(), "stat_5");
    check("valid_5", 32'(out_valid), 32'd1);

    #2;
    reset = 1'b0;
    model_fifo.delete();
    model_ovf = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_q", q_dmem, 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    tick();
    address = A_CYC;
    reset   = 1'b1;
    rd(A_CYC, 32'd0, "cycles_restart");
    rd(A_STAT, stat_exp(), "stat_restart");
    rd(A_STO, 32'd0, "stores_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
